// File: rtl/ioctl_sdram_loader_pkg.sv
// ioctl_sdram_loader_pkg: write FSM encoding and word FIFO entry layout {addr, data[16], be[2]}
package ioctl_sdram_loader_pkg;
  typedef enum logic {S_IDLE, S_REQ} state_t;
  localparam int DATA_BE_W = 18;
  function automatic int entry_w(input int addr_w);
    return addr_w + DATA_BE_W;
  endfunction
endpackage

// File: rtl/ioctl_sdram_loader_fifo.sv
// loader_fifo: synchronous FIFO; a push while full is discarded
module loader_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic wr, rd;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign wr    = push & ~full;
  assign rd    = pop & ~empty;
  assign dout  = mem_q[rp_q];
  assign count = cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr) begin
        mem_q[wp_q] <= din;
        wp_q <= wp_q + 1'b1;
      end
      if (rd) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/ioctl_sdram_loader.sv
// ioctl_sdram_loader: packs a matched ioctl byte download into 16-bit words and
// writes them to one SDRAM client port, throttling data_io through clkref_n.
module ioctl_sdram_loader
  import ioctl_sdram_loader_pkg::*;
#(
  parameter int               ADDR_W     = 22,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [5:0]       INDEX      = 6'd0,
  parameter bit               ANY_INDEX  = 1'b0,
  parameter int               FIFO_DEPTH = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              clkref_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic [1:0]        mem_be,
  input  logic              mem_ack,
  output logic              busy,
  output logic              loaded,
  output logic              err_overflow
);
  localparam int EW = entry_w(ADDR_W);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] THR = CW'(FIFO_DEPTH - 2);
  state_t state_q, state_d;
  logic active, active_q, byte_wr, lo_sel, same, flush, push, pop, full, empty;
  logic [ADDR_W-1:0] waddr, pa_q, pa_d, mem_addr_q;
  logic [7:0] nlo, nhi, plo_q, plo_d, phi_q, phi_d;
  logic [1:0] nbe, pbe_q, pbe_d, mem_be_q;
  logic pv_q, pv_d, busy_q, loaded_q, err_q;
  logic [15:0] mem_din_q;
  logic [EW-1:0] push_word, head;
  logic [CW-1:0] count;
  logic unused_idx;
  assign unused_idx = ^ioctl_index[7:6];
  assign active  = ioctl_download & (ANY_INDEX | (ioctl_index[5:0] == INDEX));
  assign byte_wr = ioctl_wr & active;
  assign waddr   = BASE_ADDR + ADDR_W'(ioctl_addr[24:1]);
  assign lo_sel  = ~ioctl_addr[0];
  assign same    = pv_q & (pa_q == waddr);
  assign nlo     = lo_sel ? ioctl_dout : (same ? plo_q : 8'h00);
  assign nhi     = !lo_sel ? ioctl_dout : (same ? phi_q : 8'h00);
  assign nbe     = (same ? pbe_q : 2'b00) | (lo_sel ? 2'b01 : 2'b10);
  assign flush   = active_q & ~active & pv_q;
  // A completed word, a displaced partial and an end-of-download flush are mutually exclusive.
  always_comb begin
    pv_d  = pv_q;
    pa_d  = pa_q;
    plo_d = plo_q;
    phi_d = phi_q;
    pbe_d = pbe_q;
    push      = byte_wr ? (nbe == 2'b11 || (pv_q && !same)) : flush;
    push_word = (byte_wr && nbe == 2'b11) ? {waddr, nhi, nlo, nbe} : {pa_q, phi_q, plo_q, pbe_q};
    if (byte_wr) begin
      pv_d  = nbe != 2'b11;
      pa_d  = waddr;
      plo_d = nlo;
      phi_d = nhi;
      pbe_d = nbe;
    end else if (flush) pv_d = 1'b0;
  end
  loader_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_sys), .rst(reset), .push(push), .din(push_word), .pop(pop),
    .dout(head), .full(full), .empty(empty), .count(count)
  );
  always_comb begin
    state_d = (state_q == S_IDLE) ? (empty ? S_IDLE : S_REQ) : (mem_ack ? S_IDLE : S_REQ);
    pop     = (state_q == S_REQ) & mem_ack;
  end
  assign busy = active | pv_q | ~empty | (state_q != S_IDLE);
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= S_IDLE;
      active_q   <= 1'b0;
      pv_q       <= 1'b0;
      pa_q       <= '0;
      plo_q      <= '0;
      phi_q      <= '0;
      pbe_q      <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_be_q   <= '0;
      busy_q     <= 1'b0;
      loaded_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active;
      pv_q     <= pv_d;
      pa_q     <= pa_d;
      plo_q    <= plo_d;
      phi_q    <= phi_d;
      pbe_q    <= pbe_d;
      if (state_q == S_IDLE && !empty) {mem_addr_q, mem_din_q, mem_be_q} <= head;
      busy_q   <= busy;
      loaded_q <= busy_q & ~busy;
      err_q    <= err_q | (push & full);
    end
  end
  assign clkref_n     = count > THR;
  assign mem_req      = state_q == S_REQ;
  assign mem_addr     = mem_addr_q;
  assign mem_din      = mem_din_q;
  assign mem_be       = mem_be_q;
  assign loaded       = loaded_q;
  assign err_overflow = err_q;
endmodule
